mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, core data/address width; only 32 and 64 are legal.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum cycles spent waiting for bus ack.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rd_en  input  1  load/fetch request from core.
REQ-006 SHALL have port wr_en  input  1  store request from core.
REQ-007 SHALL have port size  input  2  access size: 0 byte, 1 half, 2 word, 3 double.
REQ-008 SHALL have port unsigned_load  input  1  zero-extend load result when 1, else sign-extend.
REQ-009 SHALL have port mem_addr  input  DATA_SIZE  byte address from Dataflow.
REQ-010 SHALL have port wr_data  input  DATA_SIZE  store data, right-aligned.
REQ-011 SHALL have port rd_data  output  DATA_SIZE  extended load result, right-aligned.
REQ-012 SHALL have port busy  output  1  high while a request is in progress.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port misaligned  output  1  one-cycle pulse with done on misaligned/illegal-size request.
REQ-015 SHALL have port access_fault  output  1  one-cycle pulse with done on bus timeout.
REQ-016 SHALL have ports cyc_o, stb_o, we_o  output  1 each  bus cycle, strobe, write-enable.
REQ-017 SHALL have port sel_o  output  DATA_SIZE/8  byte-lane enables.
REQ-018 SHALL have ports adr_o  output  DATA_SIZE  lane-aligned address; dat_o  output  DATA_SIZE  lane-positioned write data.
REQ-019 SHALL have ports dat_i  input  DATA_SIZE  bus read data; ack_i  input  1  bus acknowledge.

Function
REQ-020 SHALL implement states IDLE, BUS, RESP; busy = (state != IDLE).
REQ-021 In IDLE, rd_en|wr_en SHALL be accepted at the edge; addr, wr_data, size, unsigned_load, direction latched; wr_en wins if both high.
REQ-022 Misaligned: size 1 with addr[0]!=0, size 2 with addr[1:0]!=0, size 3 with addr[2:0]!=0, or size 3 when DATA_SIZE=32; accepted such requests SHALL go IDLE->RESP without any bus cycle and assert misaligned with done.
REQ-023 Aligned requests SHALL go IDLE->BUS; in BUS cyc_o=stb_o=1, we_o=latched direction, held stable until ack_i.
REQ-024 adr_o SHALL be the latched address with its low log2(DATA_SIZE/8) bits cleared.
REQ-025 sel_o SHALL be the size mask (1, 3, 0xF, 0xFF) shifted left by the latched low address bits; sel_o and dat_o are 0 outside BUS.
REQ-026 dat_o SHALL be the latched wr_data shifted left by 8*(low address bits).
REQ-027 ack_i sampled high in BUS SHALL move to RESP; for loads rd_data is loaded at that edge with dat_i shifted right by 8*(low bits), truncated to size, then extended per unsigned_load.
REQ-028 A wait counter SHALL clear on entry to BUS and increment each BUS cycle without ack; reaching TIMEOUT SHALL drop cyc_o/stb_o and go to RESP with access_fault; rd_data is left unchanged.
REQ-029 RESP SHALL last exactly one cycle with done=1, then return to IDLE; new requests are not accepted in RESP.
REQ-030 Latency: request accepted at edge n, ack_i high during cycle n+1, done high during cycle n+2 (minimum); misaligned done during cycle n+1.
REQ-031 rd_data SHALL hold its value until the next successful load; stores do not modify it.
REQ-032 ack_i outside BUS SHALL be ignored; rd_en/wr_en while busy SHALL be ignored.

Reset
REQ-033 reset SHALL force IDLE, clear the counter and latches, and zero rd_data, busy, done, misaligned, access_fault, cyc_o, stb_o, we_o, sel_o, adr_o, dat_o at the next edge, including mid-BUS (bus cycle abandoned, no done).

Verification
REQ-034 DATA_SIZE=32, load byte signed at 0x1003, dat_i=0x80AB_CDEF, ack next cycle -> adr_o=0x1000, sel_o=0x8, rd_data=0xFFFF_FF80, done two cycles after request.
REQ-035 Store half 0xBEEF at 0x2002 -> we_o=1, sel_o=0xC, dat_o=0xBEEF_0000, rd_data unchanged, done after ack.
REQ-036 Load word at 0x3001 -> no cyc_o, misaligned=done=1 next cycle; also size=3 with DATA_SIZE=32 -> misaligned.
REQ-037 TIMEOUT=4, load with ack_i held low -> cyc_o drops after 4 BUS cycles, access_fault=done=1 one cycle, state IDLE after.
REQ-038 Reset asserted during BUS -> next edge cyc_o=0, busy=0, rd_data=0, no done pulse; late ack_i afterwards ignored.
REQ-039 DATA_SIZE=64, unsigned load half at 0x...06, dat_i=0xF00D_0000_0000_0000 -> sel_o=0xC0, rd_data=0xF00D.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory access unit: turns core load/store requests into single bus cycles with
// lane steering, load extension, misalignment detection and an ack timeout.
module mem_access_unit #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [1:0]             size,
    input  logic                   unsigned_load,
    input  logic [DATA_SIZE-1:0]   mem_addr,
    input  logic [DATA_SIZE-1:0]   wr_data,
    output logic [DATA_SIZE-1:0]   rd_data,
    output logic                   busy,
    output logic                   done,
    output logic                   misaligned,
    output logic                   access_fault,
    output logic                   cyc_o,
    output logic                   stb_o,
    output logic                   we_o,
    output logic [DATA_SIZE/8-1:0] sel_o,
    output logic [DATA_SIZE-1:0]   adr_o,
    output logic [DATA_SIZE-1:0]   dat_o,
    input  logic [DATA_SIZE-1:0]   dat_i,
    input  logic                   ack_i
);

    localparam int unsigned BW = DATA_SIZE / 8;
    localparam int unsigned LB = $clog2(BW);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e                state_q;
    logic [DATA_SIZE-1:0]  addr_q;
    logic [DATA_SIZE-1:0]  wdata_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic                  we_q;
    logic [CW-1:0]         wait_q;
    logic [DATA_SIZE-1:0]  rd_data_q;
    logic                  done_q;
    logic                  mis_q;
    logic                  fault_q;

    logic                  mis_req;
    logic [LB-1:0]         off;
    logic [7:0]            mask8;
    logic [15:0]           sel_wide;
    logic [DATA_SIZE-1:0]  shifted;
    logic [DATA_SIZE-1:0]  lmask;
    logic                  sbit;
    logic [DATA_SIZE-1:0]  load_val;

    // Classify the incoming request; double-word accesses are illegal on a 32-bit core.
    always_comb begin
        mis_req = 1'b0;
        case (size)
            2'd0: mis_req = 1'b0;
            2'd1: mis_req = mem_addr[0];
            2'd2: mis_req = |mem_addr[1:0];
            default: mis_req = (DATA_SIZE == 32) || (|mem_addr[2:0]);
        endcase
    end

    // Bus-side lane steering and load-result alignment/extension.
    always_comb begin
        off = addr_q[LB-1:0];
        case (size_q)
            2'd0:    mask8 = 8'h01;
            2'd1:    mask8 = 8'h03;
            2'd2:    mask8 = 8'h0F;
            default: mask8 = 8'hFF;
        endcase
        sel_wide = {8'h00, mask8} << off;

        shifted = dat_i >> {off, 3'b000};
        case (size_q)
            2'd0: begin
                lmask = DATA_SIZE'(8'hFF);
                sbit  = shifted[7];
            end
            2'd1: begin
                lmask = DATA_SIZE'(16'hFFFF);
                sbit  = shifted[15];
            end
            2'd2: begin
                lmask = DATA_SIZE'(32'hFFFF_FFFF);
                sbit  = shifted[31];
            end
            default: begin
                lmask = '1;
                sbit  = 1'b0;
            end
        endcase
        load_val = (shifted & lmask) | ((sbit & ~uns_q) ? ~lmask : '0);
    end

    // Bus outputs are live only while a bus cycle is in flight.
    always_comb begin
        cyc_o        = (state_q == StBus);
        stb_o        = cyc_o;
        we_o         = cyc_o & we_q;
        sel_o        = cyc_o ? sel_wide[BW-1:0] : '0;
        dat_o        = cyc_o ? (wdata_q << {off, 3'b000}) : '0;
        adr_o        = {addr_q[DATA_SIZE-1:LB], LB'(0)};
        busy         = (state_q != StIdle);
        done         = done_q;
        misaligned   = mis_q;
        access_fault = fault_q;
        rd_data      = rd_data_q;
    end

    // Request FSM: accept in idle, run one bus cycle or fail fast, then one response cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            we_q      <= 1'b0;
            wait_q    <= '0;
            rd_data_q <= '0;
            done_q    <= 1'b0;
            mis_q     <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (rd_en || wr_en) begin
                        addr_q  <= mem_addr;
                        wdata_q <= wr_data;
                        size_q  <= size;
                        uns_q   <= unsigned_load;
                        we_q    <= wr_en;
                        wait_q  <= '0;
                        if (mis_req) begin
                            state_q <= StResp;
                            done_q  <= 1'b1;
                            mis_q   <= 1'b1;
                        end else begin
                            state_q <= StBus;
                        end
                    end
                end
                StBus: begin
                    if (ack_i) begin
                        state_q <= StResp;
                        done_q  <= 1'b1;
                        if (!we_q) begin
                            rd_data_q <= load_val;
                        end
                    end else if (wait_q == CW'(TIMEOUT - 1)) begin
                        state_q <= StResp;
                        done_q  <= 1'b1;
                        fault_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                StResp: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
